// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types for the MIPS32 pipeline stall/flush controller.
// Holds the state encoding, the register-0 constant and the stall control bundle.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_IF_WAIT  = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_FAULT    = 2'd3
  } ctrl_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic if_stall;
    logic id_stall;
    logic id_bubble;
    logic ex_stall;
    logic mem_stall;
    logic if_flush;
  } stall_bundle_t;

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Handshake and control bundle between the pipeline datapath and the stall controller.
// The datapath side is master; the controller is slave.
interface pipeline_stall_controller_if #(parameter int CNT_W = 16);

  logic             imem_ready;
  logic             dmem_req;
  logic             dmem_ready;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_branch_taken;
  logic             fault_clear;
  logic             pc_write;
  logic             if_stall;
  logic             id_stall;
  logic             id_bubble;
  logic             ex_stall;
  logic             mem_stall;
  logic             if_flush;
  logic             mem_fault;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output imem_ready, dmem_req, dmem_ready, ex_mem_read, ex_rt, id_rs, id_rt,
           id_uses_rs, id_uses_rt, id_branch_taken, fault_clear,
    input  pc_write, if_stall, id_stall, id_bubble, ex_stall, mem_stall, if_flush,
           mem_fault, stall_count
  );

  modport slave (
    input  imem_ready, dmem_req, dmem_ready, ex_mem_read, ex_rt, id_rs, id_rt,
           id_uses_rs, id_uses_rt, id_branch_taken, fault_clear,
    output pc_write, if_stall, id_stall, id_bubble, ex_stall, mem_stall, if_flush,
           mem_fault, stall_count
  );

endinterface

// File: rtl/pipeline_stall_controller_load_use_detect.sv
// Combinational load-use hazard detector: an EX-stage load whose destination
// is read by the instruction in ID. Register 0 never creates a hazard.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  output logic       load_use
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit   = id_uses_rs && (id_rs == ex_rt);
  assign rt_hit   = id_uses_rt && (id_rt == ex_rt);
  assign load_use = ex_mem_read && (ex_rt != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the five-stage pipeline: Mealy stall controls,
// memory-wait timeout FSM with sticky fault, and a saturating stall-cycle counter.
module pipeline_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT       = 255,
  parameter int BRANCH_DELAY_SLOT = 1,
  parameter int CNT_W             = 16
)
(
  input  logic                          clock,
  input  logic                          reset,
  pipeline_stall_controller_if.slave    bus
);

  localparam int WCNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);

  localparam logic [1:0] S_RUN      = ST_RUN;
  localparam logic [1:0] S_IF_WAIT  = ST_IF_WAIT;
  localparam logic [1:0] S_MEM_WAIT = ST_MEM_WAIT;
  localparam logic [1:0] S_FAULT    = ST_FAULT;

  logic [1:0]        state, state_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic              fault_set;
  logic              fault_clr;
  logic              mem_fault;
  logic [CNT_W-1:0]  stall_count;
  logic              mem_busy;
  logic              if_busy;
  logic              load_use;
  stall_bundle_t     ctl;

  assign mem_busy = bus.dmem_req && !bus.dmem_ready;
  assign if_busy  = !bus.imem_ready;

  load_use_detect u_load_use_detect (
    .ex_mem_read (bus.ex_mem_read),
    .ex_rt       (bus.ex_rt),
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .id_uses_rs  (bus.id_uses_rs),
    .id_uses_rt  (bus.id_uses_rt),
    .load_use    (load_use)
  );

  // Everything is held low while reset is asserted, including pc_write.
  always_comb begin
    ctl = '0;
    if (!reset) begin
      ctl = '0;
    end else if (state == S_FAULT || mem_busy) begin
      ctl.id_stall  = 1'b1;
      ctl.ex_stall  = 1'b1;
      ctl.mem_stall = 1'b1;
    end else if (load_use) begin
      ctl.id_stall  = 1'b1;
      ctl.id_bubble = 1'b1;
    end else if (if_busy) begin
      ctl.if_stall  = 1'b1;
    end else begin
      ctl.pc_write  = 1'b1;
      ctl.if_flush  = bus.id_branch_taken && (BRANCH_DELAY_SLOT == 0);
    end
  end

  // wcnt holds the number of busy cycles already seen, so the compare against
  // WCNT_MAX fires on busy cycle MEM_TIMEOUT+1.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    fault_set = 1'b0;
    fault_clr = 1'b0;
    case (state)
      S_RUN: begin
        if (mem_busy || if_busy) begin
          if (wcnt == WCNT_MAX) begin
            state_nxt = S_FAULT;
            wcnt_nxt  = '0;
            fault_set = 1'b1;
          end else begin
            state_nxt = mem_busy ? S_MEM_WAIT : S_IF_WAIT;
            wcnt_nxt  = wcnt + WCNT_W'(1);
          end
        end
      end
      S_IF_WAIT: begin
        if (mem_busy) begin
          state_nxt = S_MEM_WAIT;
          wcnt_nxt  = '0;
        end else if (if_busy) begin
          if (wcnt == WCNT_MAX) begin
            state_nxt = S_FAULT;
            wcnt_nxt  = '0;
            fault_set = 1'b1;
          end else begin
            wcnt_nxt  = wcnt + WCNT_W'(1);
          end
        end else begin
          state_nxt = S_RUN;
          wcnt_nxt  = '0;
        end
      end
      S_MEM_WAIT: begin
        if (mem_busy) begin
          if (wcnt == WCNT_MAX) begin
            state_nxt = S_FAULT;
            wcnt_nxt  = '0;
            fault_set = 1'b1;
          end else begin
            wcnt_nxt  = wcnt + WCNT_W'(1);
          end
        end else begin
          state_nxt = S_RUN;
          wcnt_nxt  = '0;
        end
      end
      default: begin
        if (bus.fault_clear) begin
          state_nxt = S_RUN;
          wcnt_nxt  = '0;
          fault_clr = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_RUN;
      wcnt        <= '0;
      mem_fault   <= 1'b0;
      stall_count <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (fault_set) begin
        mem_fault <= 1'b1;
      end else if (fault_clr) begin
        mem_fault <= 1'b0;
      end
      if (!ctl.pc_write && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

  assign bus.pc_write    = ctl.pc_write;
  assign bus.if_stall    = ctl.if_stall;
  assign bus.id_stall    = ctl.id_stall;
  assign bus.id_bubble   = ctl.id_bubble;
  assign bus.ex_stall    = ctl.ex_stall;
  assign bus.mem_stall   = ctl.mem_stall;
  assign bus.if_flush    = ctl.if_flush;
  assign bus.mem_fault   = mem_fault;
  assign bus.stall_count = stall_count;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench: two controllers (no delay slot / delay slot) share directed
// stimulus; expected responses are queued per cycle and checked by a monitor.
module tb_pipeline_stall_controller;

  typedef struct packed {
    logic       rst_n;
    logic       imem_ready;
    logic       dmem_req;
    logic       dmem_ready;
    logic       ex_mem_read;
    logic [4:0] ex_rt;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       id_branch_taken;
    logic       fault_clear;
  } vec_t;

  typedef struct packed {
    logic [6:0]  ctl;
    logic        fault;
    logic [15:0] cnt;
  } exp_t;

  // ctl bit order: pc_write, if_stall, id_stall, id_bubble, ex_stall, mem_stall, if_flush
  localparam logic [6:0] C_ZERO  = 7'b0000000;
  localparam logic [6:0] C_RUN   = 7'b1000000;
  localparam logic [6:0] C_MEM   = 7'b0010110;
  localparam logic [6:0] C_LU    = 7'b0011000;
  localparam logic [6:0] C_IFB   = 7'b0100000;
  localparam logic [6:0] C_FLUSH = 7'b1000001;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  exp_t  exp_q[$];
  string name_q[$];

  pipeline_stall_controller_if #(.CNT_W(16)) bus0 ();
  pipeline_stall_controller_if #(.CNT_W(16)) bus1 ();

  pipeline_stall_controller #(.MEM_TIMEOUT(255), .BRANCH_DELAY_SLOT(0), .CNT_W(16)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  pipeline_stall_controller #(.MEM_TIMEOUT(255), .BRANCH_DELAY_SLOT(1), .CNT_W(16)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  logic [6:0] ctl0;
  logic [6:0] ctl1;
  assign ctl0 = {bus0.pc_write, bus0.if_stall, bus0.id_stall, bus0.id_bubble,
                 bus0.ex_stall, bus0.mem_stall, bus0.if_flush};
  assign ctl1 = {bus1.pc_write, bus1.if_stall, bus1.id_stall, bus1.id_bubble,
                 bus1.ex_stall, bus1.mem_stall, bus1.if_flush};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic vec_t idle();
    vec_t v;
    v = '0;
    v.rst_n = 1'b1;
    v.imem_ready = 1'b1;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    reset = v.rst_n;
    bus0.imem_ready = v.imem_ready;       bus1.imem_ready = v.imem_ready;
    bus0.dmem_req = v.dmem_req;           bus1.dmem_req = v.dmem_req;
    bus0.dmem_ready = v.dmem_ready;       bus1.dmem_ready = v.dmem_ready;
    bus0.ex_mem_read = v.ex_mem_read;     bus1.ex_mem_read = v.ex_mem_read;
    bus0.ex_rt = v.ex_rt;                 bus1.ex_rt = v.ex_rt;
    bus0.id_rs = v.id_rs;                 bus1.id_rs = v.id_rs;
    bus0.id_rt = v.id_rt;                 bus1.id_rt = v.id_rt;
    bus0.id_uses_rs = v.id_uses_rs;       bus1.id_uses_rs = v.id_uses_rs;
    bus0.id_uses_rt = v.id_uses_rt;       bus1.id_uses_rt = v.id_uses_rt;
    bus0.id_branch_taken = v.id_branch_taken;
    bus1.id_branch_taken = v.id_branch_taken;
    bus0.fault_clear = v.fault_clear;     bus1.fault_clear = v.fault_clear;
  endtask

  // One cycle of stimulus; the expected response for that cycle is queued.
  task automatic applyStimulus(input vec_t v, input logic [6:0] ctl, input logic fault,
                               input logic [15:0] cnt, input string name);
    exp_t e;
    @(posedge clock);
    #1;
    drive(v);
    e.ctl = ctl;
    e.fault = fault;
    e.cnt = cnt;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic cmp(input string n, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", n, act, req, $time);
    end
  endtask

  task automatic checkOutput(input string n, input exp_t e);
    cmp({n, ".ctl_nds"}, {9'd0, ctl0}, {9'd0, e.ctl});
    cmp({n, ".ctl_ds"}, {9'd0, ctl1}, {9'd0, e.ctl & 7'b1111110});
    cmp({n, ".fault_nds"}, {15'd0, bus0.mem_fault}, {15'd0, e.fault});
    cmp({n, ".fault_ds"}, {15'd0, bus1.mem_fault}, {15'd0, e.fault});
    cmp({n, ".count_nds"}, bus0.stall_count, e.cnt);
    cmp({n, ".count_ds"}, bus1.stall_count, e.cnt);
  endtask

  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checkOutput(n, e);
    end
  end

  initial begin
    vec_t v;
    int   c;
    checks = 0;
    errors = 0;
    v = idle();
    v.rst_n = 1'b0;
    drive(v);

    repeat (2) applyStimulus(v, C_ZERO, 1'b0, 16'd0, "reset_hold");
    applyStimulus(idle(), C_RUN, 1'b0, 16'd0, "idle_run");

    v = idle(); v.ex_mem_read = 1'b1; v.ex_rt = 5'd5; v.id_rs = 5'd5; v.id_uses_rs = 1'b1;
    applyStimulus(v, C_LU, 1'b0, 16'd0, "load_use_rs");
    applyStimulus(idle(), C_RUN, 1'b0, 16'd1, "after_load_use");
    v.ex_rt = 5'd0; v.id_rs = 5'd0;
    applyStimulus(v, C_RUN, 1'b0, 16'd1, "load_r0_no_stall");
    v = idle(); v.ex_mem_read = 1'b1; v.ex_rt = 5'd7; v.id_rt = 5'd7; v.id_uses_rt = 1'b1;
    applyStimulus(v, C_LU, 1'b0, 16'd1, "load_use_rt");
    v = idle(); v.ex_mem_read = 1'b1; v.ex_rt = 5'd9; v.id_rs = 5'd9;
    applyStimulus(v, C_RUN, 1'b0, 16'd2, "rs_not_read");

    v = idle(); v.dmem_req = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(v, C_MEM, 1'b0, 16'(2 + i), "dmem_wait");
    v.dmem_ready = 1'b1;
    applyStimulus(v, C_RUN, 1'b0, 16'd5, "dmem_done");
    applyStimulus(v, C_RUN, 1'b0, 16'd5, "dmem_same_cycle");

    v = idle(); v.id_branch_taken = 1'b1;
    applyStimulus(v, C_FLUSH, 1'b0, 16'd5, "branch_flush");
    applyStimulus(idle(), C_RUN, 1'b0, 16'd5, "after_flush");
    v.ex_mem_read = 1'b1; v.ex_rt = 5'd3; v.id_rs = 5'd3; v.id_uses_rs = 1'b1;
    applyStimulus(v, C_LU, 1'b0, 16'd5, "branch_vs_load_use");
    v = idle(); v.id_branch_taken = 1'b1;
    applyStimulus(v, C_FLUSH, 1'b0, 16'd6, "branch_reeval");

    v = idle(); v.imem_ready = 1'b0;
    applyStimulus(v, C_IFB, 1'b0, 16'd6, "imem_wait");
    applyStimulus(v, C_IFB, 1'b0, 16'd7, "imem_wait");
    applyStimulus(idle(), C_RUN, 1'b0, 16'd8, "imem_done");
    v.ex_mem_read = 1'b1; v.ex_rt = 5'd4; v.id_rt = 5'd4; v.id_uses_rt = 1'b1;
    applyStimulus(v, C_LU, 1'b0, 16'd8, "load_use_over_imem");
    applyStimulus(idle(), C_RUN, 1'b0, 16'd9, "after_lu_imem");
    v.dmem_req = 1'b1;
    applyStimulus(v, C_MEM, 1'b0, 16'd9, "mem_over_all");
    applyStimulus(idle(), C_RUN, 1'b0, 16'd10, "after_mem_over_all");

    v = idle(); v.imem_ready = 1'b0;
    applyStimulus(v, C_IFB, 1'b0, 16'd10, "if_then_mem_a");
    v = idle(); v.dmem_req = 1'b1;
    applyStimulus(v, C_MEM, 1'b0, 16'd11, "if_then_mem_b");
    applyStimulus(idle(), C_RUN, 1'b0, 16'd12, "if_then_mem_c");

    v = idle(); v.imem_ready = 1'b0;
    for (int i = 0; i < 255; i++) applyStimulus(v, C_IFB, 1'b0, 16'(12 + i), "imem_boundary");
    applyStimulus(idle(), C_RUN, 1'b0, 16'd267, "boundary_no_fault");
    applyStimulus(idle(), C_RUN, 1'b0, 16'd267, "boundary_idle");

    v = idle(); v.dmem_req = 1'b1;
    for (int i = 0; i < 11; i++) applyStimulus(v, C_MEM, 1'b0, 16'(267 + i), "dmem_pre_reset");
    v.rst_n = 1'b0;
    repeat (2) applyStimulus(v, C_ZERO, 1'b0, 16'd0, "reset_mid_wait");
    applyStimulus(idle(), C_RUN, 1'b0, 16'd0, "after_reset");
    v = idle(); v.dmem_req = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(v, C_MEM, 1'b0, 16'(i), "post_reset_wait");
    v.dmem_ready = 1'b1;
    applyStimulus(v, C_RUN, 1'b0, 16'd3, "post_reset_done");

    v = idle(); v.imem_ready = 1'b0;
    for (int i = 0; i < 256; i++) applyStimulus(v, C_IFB, 1'b0, 16'(3 + i), "imem_timeout");
    for (int i = 0; i < 3; i++) applyStimulus(idle(), C_MEM, 1'b1, 16'(259 + i), "fault_hold");
    v = idle(); v.fault_clear = 1'b1;
    applyStimulus(v, C_MEM, 1'b1, 16'd262, "fault_clear");
    applyStimulus(idle(), C_RUN, 1'b0, 16'd263, "fault_cleared");

    v = idle(); v.imem_ready = 1'b0;
    for (int i = 0; i < 256; i++) applyStimulus(v, C_IFB, 1'b0, 16'(263 + i), "refault");
    for (int j = 0; j < 65030; j++) begin
      c = 519 + j;
      applyStimulus(idle(), C_MEM, 1'b1, (c > 65535) ? 16'hFFFF : 16'(c), "saturate");
    end
    v = idle(); v.fault_clear = 1'b1;
    applyStimulus(v, C_MEM, 1'b1, 16'hFFFF, "sat_clear");
    applyStimulus(idle(), C_RUN, 1'b0, 16'hFFFF, "sat_hold");
    applyStimulus(idle(), C_RUN, 1'b0, 16'hFFFF, "sat_hold2");

    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      #1;
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Central stall/flush sequencer for the five-stage MIPS32 pipeline. It watches instruction- and data-memory handshakes, ID-stage operand use against an EX-stage load, and ID-stage branch resolution. From these it drives the per-stage stall, bubble and flush controls consumed by the IF/ID, ID/EX and EX/MEM pipeline registers and the PC. It also times out hung memory accesses and keeps a saturating stall-cycle counter for the UART debug path.

## Interface
- `MEM_TIMEOUT`, default 255: maximum wait cycles for either memory before fault.
- `BRANCH_DELAY_SLOT`, default 1: 1 means the delay slot executes; 0 means a taken branch flushes IF.
- `CNT_W`, default 16: stall counter width.

Ports:
- `clock`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `imem_ready`  in  1  instruction word valid this cycle.
- `dmem_req`  in  1  MEM stage performs a load or store.
- `dmem_ready`  in  1  data access completes this cycle.
- `ex_mem_read`  in  1  EX-stage instruction is a load.
- `ex_rt`  in  5  EX-stage load destination.
- `id_rs`, `id_rt`  in  5 each  ID-stage source registers.
- `id_uses_rs`, `id_uses_rt`  in  1 each  source actually read.
- `id_branch_taken`  in  1  branch/jump resolved taken in ID.
- `fault_clear`  in  1  leave FAULT.
- `pc_write`  out  1  PC may advance.
- `if_stall`  out  1  insert bubble into ID.
- `id_stall`  out  1  hold IF/ID register.
- `id_bubble`  out  1  insert bubble into EX.
- `ex_stall`, `mem_stall`  out  1 each  hold ID/EX and EX/MEM.
- `if_flush`  out  1  squash the fetched instruction.
- `mem_fault`  out  1  sticky timeout flag.
- `stall_count`  out  `CNT_W`  saturating count of cycles with `pc_write`=0.

## Operation
- FSM states: `RUN`, `IF_WAIT`, `MEM_WAIT`, `FAULT`. A wait counter `wcnt` has width clog2(`MEM_TIMEOUT`+1).
- Decoded conditions:
  - mem_busy = `dmem_req` & ~`dmem_ready`.
  - load_use = `ex_mem_read` & `ex_rt`≠0 & ((`id_uses_rs` & `id_rs`==`ex_rt`) | (`id_uses_rt` & `id_rt`==`ex_rt`)).
  - if_busy = ~`imem_ready`.
- Priority each cycle: FAULT > mem_busy > load_use > if_busy > branch flush.
- Outputs are Mealy, derived combinationally from state and inputs:
  - mem_busy or FAULT: `pc_write`=0 and `id_stall`=`ex_stall`=`mem_stall`=1. Everything else is 0.
  - load_use: `pc_write`=0, `id_stall`=1, `id_bubble`=1.
  - if_busy: `pc_write`=0, `if_stall`=1.
  - `id_branch_taken` & `BRANCH_DELAY_SLOT`==0 & no higher condition: `if_flush`=1.
  - Otherwise all controls are 0 and `pc_write`=1.
- State transitions:
  - RUN→MEM_WAIT on mem_busy. RUN→IF_WAIT on if_busy when no mem_busy. Load_use does not leave RUN.
  - In IF_WAIT/MEM_WAIT, `wcnt` increments each busy cycle. The state returns to RUN in the cycle after the ready input is seen.
  - If `wcnt`==`MEM_TIMEOUT` while still busy, the next state is FAULT and `mem_fault` is set.
  - IF_WAIT→MEM_WAIT if mem_busy arises while waiting; `wcnt` restarts at 0.
  - FAULT→RUN only on `fault_clear`, which also clears `mem_fault`.
- `stall_count` increments when `pc_write`=0 and saturates at all-ones. It is never cleared except by reset.

## Timing
- Control outputs have zero-cycle latency from inputs. State, `wcnt`, `mem_fault` and `stall_count` update on posedge `clock`.
- Reset (asynchronous, active-low) forces RUN, `wcnt`=0, `mem_fault`=0 and `stall_count`=0.
  - While reset is asserted all outputs are 0 except `pc_write`=0.
  - Reset mid-wait abandons the access with no fault.
- Load_use costs exactly 1 cycle. A memory wait of N busy cycles costs N stall cycles.
- `dmem_ready` and `imem_ready` asserted in the same cycle as the request mean no stall and no state change.
- Timeout: FAULT is entered after `MEM_TIMEOUT`+1 consecutive busy cycles. The boundary value `MEM_TIMEOUT` with ready arriving on the last cycle means no fault.
- Simultaneous load_use and `id_branch_taken`: stall wins and there is no flush. The branch re-evaluates next cycle.

## Structure
- Shared package `pipeline_ctrl_pkg`: state enum, the register-0 constant, and the stall-bundle struct (`pc_write`, `if_stall`, `id_stall`, `id_bubble`, `ex_stall`, `mem_stall`, `if_flush`).
- One sub-module: `load_use_detect`, combinational and producing load_use from the EX/ID register fields.

## Test plan
- Load `ex_rt`=5 with `id_rs`=5 and `id_uses_rs`=1 → exactly 1 cycle of `id_stall`=1, `id_bubble`=1, `pc_write`=0, then `stall_count`=1. The same case with `ex_rt`=0 → no stall.
- `dmem_req`=1 with `dmem_ready` low for 3 cycles → freeze outputs for 3 cycles, state MEM_WAIT, back to RUN, `stall_count`=3.
- `imem_ready` low for 256 cycles with `MEM_TIMEOUT`=255 → FAULT, `mem_fault`=1 and held; `fault_clear` pulse → RUN, `mem_fault`=0.
- Branch taken with `BRANCH_DELAY_SLOT`=0 → `if_flush`=1 for one cycle. With `BRANCH_DELAY_SLOT`=1 → no flush. With concurrent load_use → stall and no flush.
- Reset asserted during MEM_WAIT at `wcnt`=10 → immediately RUN, `stall_count`=0, no fault after release.
- Force 2^16+5 stall cycles → `stall_count` holds 0xFFFF.
